io_match_checker: RTL and testbench

- Parametrised simulation checker bound to the fabric top-level I/O (e.g. gfpga_pad_GPIO); compares a WIDTH-bit DUT vector against a reference vector every clk_pad cycle.
- Supports a bit mask and four comparison modes (equal, inverted, X/Z-only, off).
- Arms only after configuration completes plus a settle window.
- Keeps saturating error and cycle counters, captures the first failure, and optionally fires a concurrent assertion.
- Replaces the fixed-width, free-running-clock inverter check with a reset-aware, gated, counting checker.

---
 rtl/io_match_checker.sv | 170 +++++++++++++++++
 tb/tb_io_match_checker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_match_checker.sv
// rtl/io_match_checker.sv - gated, counting I/O match checker for fabric top-level pads
// Arms after config_done rises plus a settle window, then compares dut_i against ref_i each clk_pad cycle.
module io_match_checker #(
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 16,
  parameter int SETTLE    = 4,
  parameter int ASSERT_EN = 1
) (
  input  logic              clk_pad,
  input  logic              pReset_pad,
  input  logic              config_done,
  input  logic [1:0]        mode_i,
  input  logic [WIDTH-1:0]  dut_i,
  input  logic [WIDTH-1:0]  ref_i,
  input  logic [WIDTH-1:0]  mask_i,
  input  logic              clear_i,
  output logic              armed_o,
  output logic              mismatch_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [CNT_W-1:0]  cyc_cnt_o,
  output logic [WIDTH-1:0]  first_fail_vec_o,
  output logic [CNT_W-1:0]  first_fail_cyc_o,
  output logic              sticky_err_o,
  output logic              xz_err_o
);

  localparam int SET_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;

  localparam logic [1:0] MODE_EQUAL  = 2'd0;
  localparam logic [1:0] MODE_INVERT = 2'd1;
  localparam logic [1:0] MODE_XZ     = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_cfg_prev;
  logic [SET_W-1:0]   r_settle_cnt;
  logic [1:0]         r_mode;
  logic               r_mismatch;
  logic [CNT_W-1:0]   r_err_cnt;
  logic [CNT_W-1:0]   r_cyc_cnt;
  logic [WIDTH-1:0]   r_ff_vec;
  logic [CNT_W-1:0]   r_ff_cyc;
  logic               r_sticky;
  logic               r_xz;

  logic [WIDTH-1:0]   w_dut_xz;
  logic [WIDTH-1:0]   w_ref_xz;
  logic [WIDTH-1:0]   w_fv;
  logic               w_cfg_rise;
  logic               w_active;
  logic               w_fail;
  logic               w_xz_hit;
  logic               w_count_fail;

  // A bit is unknown when it is neither a clean 0 nor a clean 1 (X or Z).
  always_comb begin
    w_dut_xz = '0;
    w_ref_xz = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_dut_xz[i] = (dut_i[i] !== 1'b0) && (dut_i[i] !== 1'b1);
      w_ref_xz[i] = (ref_i[i] !== 1'b0) && (ref_i[i] !== 1'b1);
    end
  end

  always_comb begin
    w_fv = '0;
    case (r_mode)
      MODE_EQUAL:  w_fv = mask_i & (w_dut_xz | w_ref_xz | (dut_i ^ ref_i));
      MODE_INVERT: w_fv = mask_i & (w_dut_xz | w_ref_xz | ~(dut_i ^ ref_i));
      MODE_XZ:     w_fv = mask_i & w_dut_xz;
      default:     w_fv = '0;
    endcase
  end

  assign w_cfg_rise   = config_done & ~r_cfg_prev;
  assign w_active     = (r_state == ST_CHECK) && config_done;
  assign w_fail       = w_active && (|w_fv);
  assign w_xz_hit     = w_active && (|(mask_i & (w_dut_xz | w_ref_xz)));
  assign w_count_fail = w_fail && !clear_i && (r_err_cnt != {CNT_W{1'b1}});

  always_ff @(posedge clk_pad) begin
    if (pReset_pad) begin
      r_state      <= ST_IDLE;
      r_cfg_prev   <= 1'b0;
      r_settle_cnt <= '0;
      r_mode       <= MODE_EQUAL;
      r_mismatch   <= 1'b0;
      r_err_cnt    <= '0;
      r_cyc_cnt    <= '0;
      r_ff_vec     <= '0;
      r_ff_cyc     <= '0;
      r_sticky     <= 1'b0;
      r_xz         <= 1'b0;
    end else begin
      r_cfg_prev <= config_done;

      case (r_state)
        ST_IDLE: begin
          if (w_cfg_rise) begin
            if (SETTLE == 0) begin
              r_state <= ST_CHECK;
              r_mode  <= mode_i;
            end else begin
              r_state      <= ST_SETTLE;
              r_settle_cnt <= '0;
            end
          end
        end
        ST_SETTLE: begin
          if (!config_done) begin
            r_state <= ST_IDLE;
          end else if (r_settle_cnt == SET_W'(SETTLE_LAST)) begin
            r_state <= ST_CHECK;
            r_mode  <= mode_i;
          end else begin
            r_settle_cnt <= r_settle_cnt + SET_W'(1);
          end
        end
        ST_CHECK: begin
          if (!config_done) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // Clear outranks a same-cycle failure; that cycle is simply dropped.
      if (clear_i) begin
        r_mismatch <= 1'b0;
        r_err_cnt  <= '0;
        r_cyc_cnt  <= '0;
        r_ff_vec   <= '0;
        r_ff_cyc   <= '0;
        r_sticky   <= 1'b0;
        r_xz       <= 1'b0;
      end else begin
        r_mismatch <= w_fail;
        if (w_active && (r_cyc_cnt != {CNT_W{1'b1}})) r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
        if (w_fail) begin
          if (r_err_cnt != {CNT_W{1'b1}}) r_err_cnt <= r_err_cnt + CNT_W'(1);
          r_sticky <= 1'b1;
          if (!r_sticky) begin
            r_ff_vec <= w_fv;
            r_ff_cyc <= r_cyc_cnt;
          end
        end
        if (w_xz_hit) r_xz <= 1'b1;
      end
    end
  end

  assign armed_o          = (r_state == ST_CHECK);
  assign mismatch_o       = r_mismatch;
  assign err_cnt_o        = r_err_cnt;
  assign cyc_cnt_o        = r_cyc_cnt;
  assign first_fail_vec_o = r_ff_vec;
  assign first_fail_cyc_o = r_ff_cyc;
  assign sticky_err_o     = r_sticky;
  assign xz_err_o         = r_xz;

  if (ASSERT_EN != 0) begin : g_assert
    a_io_match: assert property (@(posedge clk_pad) disable iff (pReset_pad) !w_count_fail)
      else $error("io_match_checker: fv=%h cyc=%0d", w_fv, r_cyc_cnt);
  end

endmodule

// File: tb/tb_io_match_checker.sv
// tb/tb_io_match_checker.sv - table-driven and sequenced checks for io_match_checker
module tb_io_match_checker;

  logic        clk = 1'b0;
  logic        p_reset;
  logic        config_done;
  logic [1:0]  mode;
  logic [7:0]  dut;
  logic [7:0]  refv;
  logic [7:0]  mask;
  logic        clear;

  logic        armed, mis, sticky, xz;
  logic [15:0] err_cnt, cyc_cnt, ff_cyc;
  logic [7:0]  ff_vec;

  logic        armed4, mis4, sticky4, xz4;
  logic [3:0]  err4, cyc4, ff_cyc4;
  logic [7:0]  ff_vec4;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  io_match_checker #(.WIDTH(8), .CNT_W(16), .SETTLE(4), .ASSERT_EN(0)) u_dut (
    .clk_pad(clk), .pReset_pad(p_reset), .config_done(config_done), .mode_i(mode),
    .dut_i(dut), .ref_i(refv), .mask_i(mask), .clear_i(clear),
    .armed_o(armed), .mismatch_o(mis), .err_cnt_o(err_cnt), .cyc_cnt_o(cyc_cnt),
    .first_fail_vec_o(ff_vec), .first_fail_cyc_o(ff_cyc), .sticky_err_o(sticky), .xz_err_o(xz)
  );

  io_match_checker #(.WIDTH(8), .CNT_W(4), .SETTLE(0), .ASSERT_EN(0)) u_dut4 (
    .clk_pad(clk), .pReset_pad(p_reset), .config_done(config_done), .mode_i(mode),
    .dut_i(dut), .ref_i(refv), .mask_i(mask), .clear_i(clear),
    .armed_o(armed4), .mismatch_o(mis4), .err_cnt_o(err4), .cyc_cnt_o(cyc4),
    .first_fail_vec_o(ff_vec4), .first_fail_cyc_o(ff_cyc4), .sticky_err_o(sticky4), .xz_err_o(xz4)
  );

  typedef struct {
    logic [1:0] mode;
    logic [7:0] dut;
    logic [7:0] rf;
    logic [7:0] mask;
    logic       mis;
  } vec_t;

  vec_t tbl [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic rearm(input logic [1:0] m);
    config_done = 1'b0; dut = 8'h00; refv = 8'h00; mask = 8'hFF;
    tick();
    mode = m; config_done = 1'b1;
    tick();
    repeat (4) tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int    exp_err;
    int    prev_mode;
    logic  probe;
    logic [15:0] cyc_snap;

    tbl[0] = '{2'd0, 8'hA5, 8'hA5, 8'hFF, 1'b0};
    tbl[1] = '{2'd0, 8'hA4, 8'hA5, 8'hFF, 1'b1};
    tbl[2] = '{2'd0, 8'h0F, 8'h00, 8'hF0, 1'b0};
    tbl[3] = '{2'd0, 8'h1F, 8'h00, 8'hF0, 1'b1};
    tbl[4] = '{2'd1, 8'hA5, 8'h5A, 8'hFF, 1'b0};
    tbl[5] = '{2'd1, 8'hAF, 8'h5A, 8'hF0, 1'b0};
    tbl[6] = '{2'd1, 8'hA5, 8'hA5, 8'hFF, 1'b1};
    tbl[7] = '{2'd1, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[8] = '{2'd2, 8'h12, 8'h34, 8'hFF, 1'b0};
    tbl[9] = '{2'd3, 8'hFF, 8'h00, 8'hFF, 1'b0};

    p_reset = 1'b1; config_done = 1'b0; mode = 2'd0;
    dut = 8'hA5; refv = 8'hA5; mask = 8'hFF; clear = 1'b0;
    tick();
    tick();
    check("reset_armed", {31'd0, armed}, 32'd0);
    check("reset_flags", {28'd0, mis, sticky, xz, armed4}, 32'd0);
    check("reset_err", {16'd0, err_cnt}, 32'd0);
    check("reset_cyc", {16'd0, cyc_cnt}, 32'd0);
    check("reset_ff", {8'd0, ff_vec, ff_cyc}, 32'd0);

    // config_done already high on the first edge out of reset counts as a rising edge
    p_reset = 1'b0; config_done = 1'b1;
    tick();
    check("settle0_armed4", {31'd0, armed4}, 32'd1);
    repeat (3) tick();
    check("settle_not_armed", {31'd0, armed}, 32'd0);
    tick();
    check("settle_armed", {31'd0, armed}, 32'd1);
    repeat (20) tick();
    check("clean_err", {16'd0, err_cnt}, 32'd0);
    check("clean_cyc", {16'd0, cyc_cnt}, 32'd20);

    do_clear();
    check("clear_cyc", {16'd0, cyc_cnt}, 32'd0);
    repeat (7) tick();
    check("pre_fail_cyc", {16'd0, cyc_cnt}, 32'd7);
    dut = 8'hA4;
    tick();
    check("fail_mis", {31'd0, mis}, 32'd1);
    check("fail_err", {16'd0, err_cnt}, 32'd1);
    check("fail_ff_vec", {24'd0, ff_vec}, 32'h01);
    check("fail_ff_cyc", {16'd0, ff_cyc}, 32'd7);
    check("fail_sticky", {31'd0, sticky}, 32'd1);
    dut = 8'hA5;
    tick();
    check("fail_mis_clr", {31'd0, mis}, 32'd0);
    dut = 8'h00;
    tick();
    check("second_err", {16'd0, err_cnt}, 32'd2);
    check("ff_frozen", {8'd0, ff_vec, ff_cyc}, {8'd0, 8'h01, 16'd7});

    do_clear();
    exp_err = 0;
    prev_mode = -1;
    for (int i = 0; i < 10; i++) begin
      if (int'(tbl[i].mode) != prev_mode) begin
        rearm(tbl[i].mode);
        prev_mode = int'(tbl[i].mode);
      end
      dut = tbl[i].dut; refv = tbl[i].rf; mask = tbl[i].mask;
      tick();
      if (tbl[i].mis) exp_err++;
      check($sformatf("tbl%0d_mis", i), {31'd0, mis}, {31'd0, tbl[i].mis});
      check($sformatf("tbl%0d_err", i), {16'd0, err_cnt}, exp_err);
    end

    // mode_i changes during CHECK are ignored: stays EQUAL
    rearm(2'd0);
    mode = 2'd1; dut = 8'hA5; refv = 8'hA5; mask = 8'hFF;
    tick();
    check("latch_equal_match", {31'd0, mis}, 32'd0);
    refv = 8'h5A;
    tick();
    check("latch_equal_diff", {31'd0, mis}, 32'd1);

    rearm(2'd0);
    do_clear();
    dut = 8'h00; refv = 8'hFF; mask = 8'hFF;
    repeat (20) tick();
    check("sat_err4", {28'd0, err4}, 32'd15);
    check("sat_cyc4", {28'd0, cyc4}, 32'd15);
    check("sat_ffcyc4", {28'd0, ff_cyc4}, 32'd0);
    check("sat_err16", {16'd0, err_cnt}, 32'd20);

    probe = 1'bx;
    if (probe !== 1'b0 && probe !== 1'b1) begin
      rearm(2'd2);
      do_clear();
      dut = 8'b0000_x000; refv = 8'h00; mask = 8'h08;
      tick();
      check("xz_flag", {31'd0, xz}, 32'd1);
      check("xz_err", {16'd0, err_cnt}, 32'd1);
      mask = 8'hF7;
      tick();
      check("xz_masked_err", {16'd0, err_cnt}, 32'd1);
    end

    rearm(2'd0);
    do_clear();
    dut = 8'hA4; refv = 8'hA5;
    tick();
    dut = 8'hA5;
    tick();
    config_done = 1'b0;
    tick();
    check("drop_armed", {31'd0, armed}, 32'd0);
    cyc_snap = cyc_cnt;
    dut = 8'h00; refv = 8'hFF;
    repeat (3) tick();
    check("drop_err_held", {16'd0, err_cnt}, 32'd1);
    check("drop_cyc_held", {16'd0, cyc_cnt}, {16'd0, cyc_snap});
    check("drop_mis", {31'd0, mis}, 32'd0);
    rearm(2'd0);
    check("rearm_err_kept", {16'd0, err_cnt}, 32'd1);
    check("rearm_sticky_kept", {31'd0, sticky}, 32'd1);

    dut = 8'h00; refv = 8'hFF; clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_fail_err", {16'd0, err_cnt}, 32'd0);
    check("clr_fail_cyc", {16'd0, cyc_cnt}, 32'd0);
    check("clr_fail_flags", {30'd0, mis, sticky}, 32'd0);
    check("clr_fail_armed", {31'd0, armed}, 32'd1);
    tick();
    check("resume_err", {16'd0, err_cnt}, 32'd1);
    check("resume_cyc", {16'd0, cyc_cnt}, 32'd1);
    check("resume_ff", {8'd0, ff_vec, ff_cyc}, {8'd0, 8'hFF, 16'd0});

    p_reset = 1'b1;
    tick();
    check("midreset_armed", {30'd0, armed, armed4}, 32'd0);
    check("midreset_cnt", {err_cnt, cyc_cnt}, 32'd0);
    check("midreset_flags", {29'd0, mis, sticky, xz}, 32'd0);
    check("midreset_ff", {8'd0, ff_vec, ff_cyc}, 32'd0);
    p_reset = 1'b0; dut = 8'h3C; refv = 8'h3C;
    repeat (4) tick();
    check("rearm_after_reset_wait", {31'd0, armed}, 32'd0);
    tick();
    check("rearm_after_reset", {31'd0, armed}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
